// File: rtl/control_block.sv
`default_nettype none
// ============================================================================
// Module   : control_block
// Purpose  : Multi-cycle MIPS-subset control unit. A one-hot stage register
//            sequences IF/ID/EX/MEM/WB/HALT. Instruction decode (register
//            addresses, immediate, ALU op, branch/jump target) is purely
//            combinational from IR. Datapath strobes and selects are
//            derived from the current stage and the decoded instruction.
// Revision : 1.0 - initial release
// ============================================================================
module control_block (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic [31:0] regrs,
    input  logic [31:0] regrt,
    output logic [5:0]  stage,
    output logic        IR_DR,
    output logic        MemWrite,
    output logic [5:0]  funct,
    output logic [4:0]  rout1,
    output logic [4:0]  rout2,
    output logic [4:0]  rin,
    output logic [31:0] imm,
    output logic        addr_mux,
    output logic        Din_mux,
    output logic        AddrOrData_mux,
    output logic        MemOrReg_mux,
    output logic        Store_mux,
    output logic        imm_mux,
    output logic        PCcount,
    output logic        RegWrite,
    output logic [31:0] addr_imm
);

    typedef enum logic [5:0] {
        ST_IF   = 6'b000001,
        ST_ID   = 6'b000010,
        ST_EX   = 6'b000100,
        ST_MEM  = 6'b001000,
        ST_WB   = 6'b010000,
        ST_HALT = 6'b100000
    } stage_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b100111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_ADDU = 6'b100001;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_XOR  = 6'b100110;
    localparam logic [5:0] ALU_SLT  = 6'b101010;

    stage_t      stage_q;
    stage_t      stage_d;
    stage_t      stage_cur;

    logic [5:0]  opcode;
    logic        op_r;
    logic        op_jr;
    logic        op_alui;
    logic        op_lw;
    logic        op_sw;
    logic        op_beq;
    logic        op_bne;
    logic        op_j;
    logic        op_jal;
    logic        op_halt;
    logic        op_itype;
    logic        br_taken;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign opcode   = IR[31:26];
    assign rout1    = IR[25:21];
    assign rout2    = IR[20:16];
    assign imm_sext = {{16{IR[15]}}, IR[15:0]};
    assign imm_zext = {16'h0000, IR[15:0]};
    assign op_itype = op_alui | op_lw | op_sw;
    assign br_taken = (op_beq & (regrs == regrt)) | (op_bne & (regrs != regrt));

    // Classify the instruction; unknown opcodes leave every flag low (NOP)
    always_comb begin
        op_r    = 1'b0;
        op_jr   = 1'b0;
        op_alui = 1'b0;
        op_lw   = 1'b0;
        op_sw   = 1'b0;
        op_beq  = 1'b0;
        op_bne  = 1'b0;
        op_j    = 1'b0;
        op_jal  = 1'b0;
        op_halt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                op_r  = (IR[5:0] != FN_JR);
                op_jr = (IR[5:0] == FN_JR);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI: op_alui = 1'b1;
            OP_LW:   op_lw   = 1'b1;
            OP_SW:   op_sw   = 1'b1;
            OP_BEQ:  op_beq  = 1'b1;
            OP_BNE:  op_bne  = 1'b1;
            OP_J:    op_j    = 1'b1;
            OP_JAL:  op_jal  = 1'b1;
            OP_HALT: op_halt = 1'b1;
            default: ;
        endcase
    end

    // Immediate extension and ALU operation selection per opcode
    always_comb begin
        imm   = 32'h0;
        funct = 6'b000000;
        case (opcode)
            OP_RTYPE: funct = IR[5:0];
            OP_ADDI:  begin imm = imm_sext;            funct = ALU_ADD;  end
            OP_ADDIU: begin imm = imm_sext;            funct = ALU_ADDU; end
            OP_SLTI:  begin imm = imm_sext;            funct = ALU_SLT;  end
            OP_ANDI:  begin imm = imm_zext;            funct = ALU_AND;  end
            OP_ORI:   begin imm = imm_zext;            funct = ALU_OR;   end
            OP_XORI:  begin imm = imm_zext;            funct = ALU_XOR;  end
            OP_LUI:   begin imm = {IR[15:0], 16'h0};   funct = ALU_ADD;  end
            OP_LW:    begin imm = imm_sext;            funct = ALU_ADD;  end
            OP_SW:    begin imm = imm_sext;            funct = ALU_ADD;  end
            OP_BEQ:   begin imm = imm_sext;            funct = ALU_SUB;  end
            OP_BNE:   begin imm = imm_sext;            funct = ALU_SUB;  end
            default:  ;
        endcase
    end

    // Write-back register address and PC target value
    always_comb begin
        rin      = IR[20:16];
        addr_imm = 32'h0;
        if (op_r | op_jr) begin
            rin = IR[15:11];
        end
        if (op_jal) begin
            rin = 5'd31;
        end
        if (op_j | op_jal) begin
            addr_imm = {4'b0000, IR[25:0], 2'b00};
        end else if (op_beq | op_bne) begin
            addr_imm = {imm_sext[29:0], 2'b00};
        end else if (op_jr) begin
            addr_imm = regrs;
        end
    end

    // Any non-one-hot register value, including an all-zero power-up, acts as IF
    always_comb begin
        case (stage_q)
            ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_HALT: stage_cur = stage_q;
            default:                                     stage_cur = ST_IF;
        endcase
    end

    assign stage = stage_cur;

    // Stage sequencing: route depends on the instruction class decoded in ID
    always_comb begin
        stage_d = ST_IF;
        case (stage_cur)
            ST_IF: stage_d = ST_ID;
            ST_ID: begin
                if (op_halt) begin
                    stage_d = ST_HALT;
                end else if (op_r | op_itype) begin
                    stage_d = ST_EX;
                end else begin
                    stage_d = ST_IF;
                end
            end
            ST_EX:   stage_d = (op_lw | op_sw) ? ST_MEM : ST_WB;
            ST_MEM:  stage_d = op_lw ? ST_WB : ST_IF;
            ST_WB:   stage_d = ST_IF;
            ST_HALT: stage_d = ST_HALT;
            default: stage_d = ST_IF;
        endcase
    end

    // Stage register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= ST_IF;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Datapath strobes and selects; all held low while reset is asserted
    always_comb begin
        IR_DR          = 1'b0;
        MemWrite       = 1'b0;
        addr_mux       = 1'b0;
        Din_mux        = 1'b0;
        AddrOrData_mux = 1'b0;
        MemOrReg_mux   = 1'b0;
        Store_mux      = 1'b0;
        imm_mux        = 1'b0;
        PCcount        = 1'b0;
        RegWrite       = 1'b0;
        if (!reset) begin
            case (stage_cur)
                ST_IF: begin
                    IR_DR   = 1'b1;
                    PCcount = 1'b1;
                end
                ST_ID: begin
                    if (br_taken | op_j | op_jr | op_jal) begin
                        PCcount   = 1'b1;
                        Store_mux = 1'b1;
                    end
                    if (op_jal) begin
                        RegWrite = 1'b1;
                        Din_mux  = 1'b1;
                    end
                end
                ST_EX: begin
                    imm_mux = op_itype;
                end
                ST_MEM: begin
                    addr_mux = 1'b1;
                    MemWrite = op_sw;
                end
                ST_WB: begin
                    RegWrite     = 1'b1;
                    MemOrReg_mux = op_lw;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_block
// Purpose  : Self-checking bench for control_block. A route-based model
//            (list of stages each instruction class walks through) predicts
//            stage, strobes and decode outputs every cycle under directed
//            and randomized instructions, register values and resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_block;

    logic        clk;
    logic        reset;
    logic [31:0] IR;
    logic [31:0] regrs;
    logic [31:0] regrt;
    logic [5:0]  stage;
    logic        IR_DR, MemWrite, addr_mux, Din_mux, AddrOrData_mux;
    logic        MemOrReg_mux, Store_mux, imm_mux, PCcount, RegWrite;
    logic [5:0]  funct;
    logic [4:0]  rout1, rout2, rin;
    logic [31:0] imm, addr_imm;

    int checks = 0;
    int errors = 0;
    int pos    = 0;   // position within the current instruction's route

    localparam int K_R = 0, K_JR = 1, K_ALUI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
    localparam int K_BNE = 6, K_J = 7, K_JAL = 8, K_HALT = 9, K_NOP = 10;
    localparam int S_IF = 0, S_ID = 1, S_EX = 2, S_MEM = 3, S_WB = 4, S_HALT = 5;

    control_block dut (
        .clk(clk), .reset(reset), .IR(IR), .regrs(regrs), .regrt(regrt),
        .stage(stage), .IR_DR(IR_DR), .MemWrite(MemWrite), .funct(funct),
        .rout1(rout1), .rout2(rout2), .rin(rin), .imm(imm),
        .addr_mux(addr_mux), .Din_mux(Din_mux), .AddrOrData_mux(AddrOrData_mux),
        .MemOrReg_mux(MemOrReg_mux), .Store_mux(Store_mux), .imm_mux(imm_mux),
        .PCcount(PCcount), .RegWrite(RegWrite), .addr_imm(addr_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int classify(input logic [31:0] ir);
        case (int'(ir[31:26]))
            0:                            return (ir[5:0] == 6'd8) ? K_JR : K_R;
            8, 9, 10, 12, 13, 14, 15:     return K_ALUI;
            35:                           return K_LW;
            43:                           return K_SW;
            4:                            return K_BEQ;
            5:                            return K_BNE;
            2:                            return K_J;
            3:                            return K_JAL;
            39:                           return K_HALT;
            default:                      return K_NOP;
        endcase
    endfunction

    function automatic int route_len(input int k);
        case (k)
            K_R, K_ALUI, K_SW: return 4;
            K_LW:              return 5;
            K_HALT:            return 3;
            default:           return 2;
        endcase
    endfunction

    function automatic int route_stage(input int k, input int p);
        case (p)
            0:       return S_IF;
            1:       return S_ID;
            2:       return (k == K_HALT) ? S_HALT : S_EX;
            3:       return (k == K_LW || k == K_SW) ? S_MEM : S_WB;
            default: return S_WB;
        endcase
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] v);
        return 32'($signed(v));
    endfunction

    function automatic logic [31:0] exp_funct(input logic [31:0] ir);
        case (int'(ir[31:26]))
            0:           return {26'h0, ir[5:0]};
            8, 35, 43, 15: return 32'h20;
            9:           return 32'h21;
            10:          return 32'h2A;
            12:          return 32'h24;
            13:          return 32'h25;
            14:          return 32'h26;
            4, 5:        return 32'h22;
            default:     return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] ir);
        case (int'(ir[31:26]))
            8, 9, 10, 35, 43, 4, 5: return sx(ir[15:0]);
            12, 13, 14:             return {16'h0, ir[15:0]};
            15:                     return {16'h0, ir[15:0]} * 32'h10000;
            default:                return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h (t=%0t IR=%h)", name, act, exp, $time, IR);
        end
    endtask

    // Compare every output against the model for the current cycle
    task automatic compare_all();
        int k, s;
        logic eq;
        logic e_irdr, e_mw, e_am, e_din, e_aod, e_mor, e_sm, e_imx, e_pc, e_rw;
        logic [31:0] e_rin, e_ai;
        #1;
        k  = classify(IR);
        s  = reset ? S_IF : route_stage(k, pos);
        eq = (regrs == regrt);
        {e_irdr, e_mw, e_am, e_din, e_aod, e_mor, e_sm, e_imx, e_pc, e_rw} = '0;
        if (!reset) begin
            if (s == S_IF) begin e_irdr = 1; e_pc = 1; end
            if (s == S_ID) begin
                if (k == K_J || k == K_JR || k == K_JAL || (k == K_BEQ && eq) || (k == K_BNE && !eq)) begin
                    e_pc = 1; e_sm = 1;
                end
                if (k == K_JAL) begin e_rw = 1; e_din = 1; end
            end
            if (s == S_EX)  e_imx = (k == K_ALUI || k == K_LW || k == K_SW);
            if (s == S_MEM) begin e_am = 1; e_mw = (k == K_SW); end
            if (s == S_WB)  begin e_rw = 1; e_mor = (k == K_LW); end
        end
        chk("stage", {26'h0, stage}, 32'h1 << s);
        chk("IR_DR", {31'h0, IR_DR}, {31'h0, e_irdr});
        chk("MemWrite", {31'h0, MemWrite}, {31'h0, e_mw});
        chk("addr_mux", {31'h0, addr_mux}, {31'h0, e_am});
        chk("Din_mux", {31'h0, Din_mux}, {31'h0, e_din});
        chk("AddrOrData_mux", {31'h0, AddrOrData_mux}, {31'h0, e_aod});
        chk("MemOrReg_mux", {31'h0, MemOrReg_mux}, {31'h0, e_mor});
        chk("Store_mux", {31'h0, Store_mux}, {31'h0, e_sm});
        chk("imm_mux", {31'h0, imm_mux}, {31'h0, e_imx});
        chk("PCcount", {31'h0, PCcount}, {31'h0, e_pc});
        chk("RegWrite", {31'h0, RegWrite}, {31'h0, e_rw});
        chk("rout1", {27'h0, rout1}, {27'h0, IR[25:21]});
        chk("rout2", {27'h0, rout2}, {27'h0, IR[20:16]});
        if (k != K_J && k != K_HALT && k != K_NOP) begin
            e_rin = (k == K_JAL) ? 32'd31 : (k == K_R || k == K_JR) ? {27'h0, IR[15:11]} : {27'h0, IR[20:16]};
            chk("rin", {27'h0, rin}, e_rin);
        end
        chk("funct", {26'h0, funct}, exp_funct(IR));
        chk("imm", imm, exp_imm(IR));
        if (k == K_J || k == K_JAL)        e_ai = (IR & 32'h03FF_FFFF) * 4;
        else if (k == K_BEQ || k == K_BNE) e_ai = sx(IR[15:0]) * 4;
        else if (k == K_JR)                e_ai = regrs;
        else                               e_ai = 32'h0;
        chk("addr_imm", addr_imm, e_ai);
    endtask

    // Advance the model across one rising edge, ending at the falling edge
    task automatic tick();
        int k;
        @(posedge clk);
        k = classify(IR);
        if (reset)                        pos = 0;
        else if (!(k == K_HALT && pos == 2)) pos = (pos + 1) % route_len(k);
        @(negedge clk);
    endtask

    task automatic step();
        tick();
        compare_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int sel, op;
        r   = $urandom;
        sel = $urandom_range(0, 10);
        case (sel)
            K_R:    return {6'd0, r[25:6], (r[5:0] == 6'd8) ? 6'h20 : r[5:0]};
            K_JR:   return {6'd0, r[25:6], 6'd8};
            K_ALUI: begin
                case ($urandom_range(0, 6))
                    0: op = 8;  1: op = 9;  2: op = 10; 3: op = 12;
                    4: op = 13; 5: op = 14; default: op = 15;
                endcase
                return {6'(op), r[25:0]};
            end
            K_LW:   return {6'd35, r[25:0]};
            K_SW:   return {6'd43, r[25:0]};
            K_BEQ:  return {6'd4, r[25:0]};
            K_BNE:  return {6'd5, r[25:0]};
            K_J:    return {6'd2, r[25:0]};
            K_JAL:  return {6'd3, r[25:0]};
            K_HALT: return {6'd39, r[25:0]};
            default: begin
                op = $urandom_range(0, 63);
                while (classify({6'(op), 26'h0}) != K_NOP) op = $urandom_range(0, 63);
                return {6'(op), r[25:0]};
            end
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        IR    = 32'h2020_0003;   // addi $0,$1,3 from power-up, no reset
        regrs = 32'h0;
        regrt = 32'h0;

        compare_all();
        chk("pin_if_stage", {26'h0, stage}, 32'h01);
        chk("pin_if_pc", {31'h0, PCcount}, 32'h1);
        chk("pin_addi_rout1", {27'h0, rout1}, 32'd1);
        chk("pin_addi_rin", {27'h0, rin}, 32'd0);
        chk("pin_addi_imm", imm, 32'd3);
        chk("pin_addi_funct", {26'h0, funct}, 32'h20);
        step(); chk("pin_id_stage", {26'h0, stage}, 32'h02);
        chk("pin_id_pc", {31'h0, PCcount}, 32'h0);
        step(); chk("pin_ex_stage", {26'h0, stage}, 32'h04);
        chk("pin_ex_immmux", {31'h0, imm_mux}, 32'h1);
        step(); chk("pin_wb_stage", {26'h0, stage}, 32'h10);
        chk("pin_wb_rw", {31'h0, RegWrite}, 32'h1);
        step(); chk("pin_wrap_stage", {26'h0, stage}, 32'h01);

        IR = 32'h8C22_FFFC;      // lw $2,-4($1)
        compare_all(); chk("pin_lw_imm", imm, 32'hFFFF_FFFC);
        step(); step(); step();
        chk("pin_lw_mem_stage", {26'h0, stage}, 32'h08);
        chk("pin_lw_mem_addr", {31'h0, addr_mux}, 32'h1);
        chk("pin_lw_mem_irdr", {31'h0, IR_DR}, 32'h0);
        step();
        chk("pin_lw_wb_mor", {31'h0, MemOrReg_mux}, 32'h1);
        chk("pin_lw_wb_rin", {27'h0, rin}, 32'd2);
        step();

        IR = 32'h1022_0004; regrs = 32'd5; regrt = 32'd5;   // beq, taken
        step();
        chk("pin_beq_pc", {31'h0, PCcount}, 32'h1);
        chk("pin_beq_sm", {31'h0, Store_mux}, 32'h1);
        chk("pin_beq_target", addr_imm, 32'h10);
        step(); chk("pin_beq_back_if", {26'h0, stage}, 32'h01);
        regrt = 32'd6;                                     // beq, not taken
        step(); chk("pin_beq_nt_pc", {31'h0, PCcount}, 32'h0);
        step();

        IR = 32'h0C00_0010;      // jal
        step();
        chk("pin_jal_target", addr_imm, 32'h40);
        chk("pin_jal_rin", {27'h0, rin}, 32'd31);
        chk("pin_jal_rw", {31'h0, RegWrite}, 32'h1);
        chk("pin_jal_din", {31'h0, Din_mux}, 32'h1);
        step();

        IR = 32'h3421_FFFF;      // ori
        compare_all();
        chk("pin_ori_imm", imm, 32'h0000_FFFF);
        chk("pin_ori_funct", {26'h0, funct}, 32'h25);
        IR = 32'h3C01_1234;      // lui
        compare_all();
        chk("pin_lui_imm", imm, 32'h1234_0000);
        step(); step(); step(); step();

        IR = 32'h9C00_0000;      // halt
        step(); step();
        chk("pin_halt_stage", {26'h0, stage}, 32'h20);
        step();
        chk("pin_halt_held", {26'h0, stage}, 32'h20);
        chk("pin_halt_pc", {31'h0, PCcount}, 32'h0);
        #2 reset = 1'b1;
        pos = 0;
        #1 chk("pin_async_reset", {26'h0, stage}, 32'h01);
        chk("pin_reset_irdr", {31'h0, IR_DR}, 32'h0);
        compare_all();
        tick();
        reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            if (reset) begin
                reset = 1'b0;
            end else if (($urandom % 50 == 0) ||
                         (pos == 2 && classify(IR) == K_HALT && ($urandom % 3 == 0))) begin
                reset = 1'b1;
                pos   = 0;
            end
            if (pos == 0) IR = rand_instr();
            regrs = $urandom;
            regrt = ($urandom % 2 == 0) ? regrs : $urandom;
            compare_all();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
